muxreg_pipe: RTL and testbench
==============================

MUXREG_PIPE -- requirements
Module: muxreg_pipe

Interface
- REQ-001 SHALL have parameter WIDTH, default 16: data width of each channel and of q.
- REQ-002 SHALL have parameter NCH, default 8, range 2..16: number of input channels.
- REQ-003 SHALL derive localparam SELW = clog2(NCH), minimum 1.
- REQ-004 SHALL have port CLK, input, 1: rising-edge clock.
- REQ-005 SHALL have port RSTN, input, 1: asynchronous, active-low reset.
- REQ-006 SHALL have port d, input, NCH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- REQ-007 SHALL have port d_valid, input, NCH: per-channel data-valid.
- REQ-008 SHALL have port d_ready, output, NCH: per-channel accept strobe, one-hot or zero.
- REQ-009 SHALL have port load, input, 1: explicit-mode capture request.
- REQ-010 SHALL have port sel, input, SELW: explicit-mode channel index.
- REQ-011 SHALL have port mode, input, 1: 0 = explicit select, 1 = round-robin.
- REQ-012 SHALL have port q, output, WIDTH: registered output data.
- REQ-013 SHALL have port q_valid, output, 1: q holds an undelivered word.
- REQ-014 SHALL have port q_ready, input, 1: downstream accepts q this cycle.
- REQ-015 SHALL have port q_src, output, SELW: channel index that supplied q.
- REQ-016 SHALL have port sel_err, output, 1: sticky flag for an out-of-range sel.

Function
- REQ-017 SHALL define slot_free = !q_valid || q_ready; no capture SHALL occur when slot_free is 0.
- REQ-018 Explicit mode SHALL capture d[sel] into q, sel into q_src, and set q_valid when load=1, sel<NCH, d_valid[sel]=1 and slot_free=1.
- REQ-019 SHALL drive d_ready[i]=1 only in the cycle channel i is captured, combinationally from the current-cycle inputs and state.
- REQ-020 Explicit mode with load=1 and d_valid[sel]=0 SHALL produce no capture and leave q unchanged.
- REQ-021 Explicit mode with load=1 and sel>=NCH SHALL produce no capture and set sel_err to 1 on the next edge.
- REQ-022 Round-robin mode SHALL ignore load and sel.
- REQ-023 Round-robin mode SHALL grant the first channel with d_valid=1, searching from ptr upward modulo NCH.
- REQ-024 After each round-robin capture, ptr SHALL become (grant+1) mod NCH, wrapping from NCH-1 to 0.
- REQ-025 Round-robin mode SHALL hold ptr unchanged when no capture occurs.
- REQ-026 When q_valid=1 and q_ready=0, q and q_src SHALL hold stable.
- REQ-027 A transfer (q_valid && q_ready) with no capture in the same cycle SHALL clear q_valid on the next edge.
- REQ-028 A transfer and a capture in the same cycle SHALL load the new word with q_valid remaining 1, giving full throughput of one word per cycle.
- REQ-029 A capture into an empty slot SHALL make q and q_valid visible one cycle after the capture edge's inputs.
- REQ-030 A mode change SHALL NOT disturb a held word or ptr.

Reset
- REQ-031 RSTN=0 SHALL asynchronously force q=0, q_valid=0, q_src=0, ptr=0 and sel_err=0.
- REQ-032 During reset, d_ready SHALL be all zero.
- REQ-033 A word held at reset assertion SHALL be discarded.
- REQ-034 sel_err SHALL clear only on reset.

Configuration
- REQ-035 Macro MUXREG_PIPE_RR_EN defined: round-robin mode, ptr and the arbiter SHALL be compiled in per REQ-022..025.
- REQ-036 Macro MUXREG_PIPE_RR_EN undefined: no arbiter or ptr logic SHALL exist, the mode input SHALL be ignored, and the block SHALL always behave in explicit mode.

Verification
- REQ-037 Explicit capture: NCH=8; sel=3, load=1, d_valid=8'h08, d[3]=16'hBEEF, q_ready=1 -> next cycle q=16'hBEEF, q_src=3, q_valid=1; d_ready=8'h08 in the capture cycle.
- REQ-038 Backpressure: q_valid=1, q_ready=0, load=1, d_valid[sel]=1 for 3 cycles -> q unchanged, d_ready=0; q_ready=1 -> new word captured the same cycle, q_valid stays 1.
- REQ-039 Out-of-range: NCH=6, sel=7, load=1 -> no capture, sel_err=1 next cycle and still 1 after 10 idle cycles.
- REQ-040 Round-robin wrap (RR_EN defined): mode=1, d_valid=8'b1000_0001 held, q_ready=1 -> q_src sequence 0,7,0,7; ptr reaches 0 after granting 7.
- REQ-041 Reset mid-operation: q_valid=1, q=16'h1234; pulse RSTN low between edges -> q=0, q_valid=0, sel_err=0 immediately, without waiting for a clock edge.
- REQ-042 Compile-out (RR_EN undefined): mode=1, load=1, sel=2, d_valid[2]=1 -> explicit capture of d[2].

Source files
------------

// File: rtl/muxreg_pipe.sv
// muxreg_pipe: NCH-channel multiplexer into a single registered output slot.
// Define MUXREG_PIPE_RR_EN to compile in the round-robin arbiter (mode=1).
module muxreg_pipe #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [NCH*WIDTH-1:0] d,
    input  logic [NCH-1:0]       d_valid,
    output logic [NCH-1:0]       d_ready,
    input  logic                 load,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    input  logic                 q_ready,
    output logic [SELW-1:0]      q_src,
    output logic                 sel_err
);

    // Handshakes: an input word moves when d_valid[i] && d_ready[i]; d_ready is a
    // one-hot accept strobe, high only in the capture cycle. The output word moves
    // when q_valid && q_ready; q/q_src stay stable while q_valid && !q_ready.

    localparam int NPAD = 1 << SELW;

    logic [NPAD-1:0]  dv_pad;
    logic [31:0]      sel_ext;
    logic             sel_ok;
    logic             exp_hit;
    logic             slot_free;
    logic             rr_mode;
    logic             hit;
    logic             cap;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] cap_data;

    // Padding lets sel index the valid vector even when it points past NCH-1.
    assign dv_pad    = NPAD'(d_valid);
    assign sel_ext   = 32'(sel);
    assign sel_ok    = sel_ext < 32'(NCH);
    assign exp_hit   = load && sel_ok && dv_pad[sel];
    assign slot_free = !q_valid || q_ready;

`ifdef MUXREG_PIPE_RR_EN
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] rr_idx;
    logic            rr_found;
    logic [SELW:0]   cand;

    assign rr_mode = mode;

    // First requester at or above ptr, wrapping modulo NCH.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, ptr} + (SELW+1)'(k);
            if (cand >= (SELW+1)'(NCH)) begin
                cand = cand - (SELW+1)'(NCH);
            end
            if (!rr_found && dv_pad[cand[SELW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[SELW-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ptr <= '0;
        end else if (cap && rr_mode) begin
            ptr <= (rr_idx == SELW'(NCH-1)) ? '0 : rr_idx + 1'b1;
        end
    end

    assign grant = rr_mode ? rr_idx : sel;
    assign hit   = rr_mode ? rr_found : exp_hit;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign rr_mode     = 1'b0;
    assign grant       = sel;
    assign hit         = exp_hit;
`endif

    // Gating with RSTN keeps d_ready quiet while reset is held.
    assign cap = RSTN && slot_free && hit;

    always_comb begin
        d_ready  = '0;
        cap_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == SELW'(i)) begin
                d_ready[i] = cap;
                cap_data   = d[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            q       <= '0;
            q_src   <= '0;
            q_valid <= 1'b0;
        end else if (cap) begin
            q       <= cap_data;
            q_src   <= grant;
            q_valid <= 1'b1;
        end else if (q_ready) begin
            q_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sel_err <= 1'b0;
        end else if (!rr_mode && load && !sel_ok) begin
            sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_muxreg_pipe.sv
// tb_muxreg_pipe: table vectors, directed corner sequences and randomized traffic
// for muxreg_pipe (NCH=8 main instance, NCH=6 instance for out-of-range sel).
module tb_muxreg_pipe;
    localparam int WIDTH = 16;
    localparam int NCH   = 8;
    localparam int SELW  = 3;
    localparam int NCH6  = 6;

    logic CLK = 1'b0;
    logic RSTN;
    always #5 CLK = ~CLK;

    logic [NCH*WIDTH-1:0] d;
    logic [NCH-1:0]       d_valid;
    logic [NCH-1:0]       d_ready;
    logic                 load;
    logic [SELW-1:0]      sel;
    logic                 mode;
    logic [WIDTH-1:0]     q;
    logic                 q_valid;
    logic                 q_ready;
    logic [SELW-1:0]      q_src;
    logic                 sel_err;

    logic [NCH6*WIDTH-1:0] d6;
    logic [NCH6-1:0]       d6_valid;
    logic [NCH6-1:0]       d6_ready;
    logic                  load6;
    logic [SELW-1:0]       sel6;
    logic                  mode6;
    logic [WIDTH-1:0]      q6;
    logic                  q6_valid;
    logic                  q6_ready;
    logic [SELW-1:0]       q6_src;
    logic                  sel6_err;

    muxreg_pipe #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .CLK(CLK), .RSTN(RSTN), .d(d), .d_valid(d_valid), .d_ready(d_ready),
        .load(load), .sel(sel), .mode(mode), .q(q), .q_valid(q_valid),
        .q_ready(q_ready), .q_src(q_src), .sel_err(sel_err)
    );

    muxreg_pipe #(.WIDTH(WIDTH), .NCH(NCH6)) dut6 (
        .CLK(CLK), .RSTN(RSTN), .d(d6), .d_valid(d6_valid), .d_ready(d6_ready),
        .load(load6), .sel(sel6), .mode(mode6), .q(q6), .q_valid(q6_valid),
        .q_ready(q6_ready), .q_src(q6_src), .sel_err(sel6_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: words captured but not yet delivered, as {src, data}.
    logic [SELW+WIDTH-1:0] exp_q[$];
    int                    m_ptr;
    logic [NCH-1:0]        last_dready;

    function automatic logic [WIDTH-1:0] chan(input logic [NCH*WIDTH-1:0] bus, input int i);
        return bus[i*WIDTH +: WIDTH];
    endfunction

    function automatic int pick_rr(input logic [NCH-1:0] dv, input int p);
        int order[$];
        for (int k = 0; k < NCH; k++) order.push_back((p + k) % NCH);
        foreach (order[j]) if (dv[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ptr = 0;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic do_cycle(input logic ld, input logic [SELW-1:0] s, input logic [NCH-1:0] dv,
                            input logic qr, input logic md);
        int   g;
        logic rr;
        logic [NCH-1:0] exp_dr;
        load = ld; sel = s; d_valid = dv; q_ready = qr; mode = md;
        @(negedge CLK);
        g  = -1;
        rr = 1'b0;
`ifdef MUXREG_PIPE_RR_EN
        rr = md;
`endif
        if (rr) g = pick_rr(dv, m_ptr);
        else if (ld && dv[s]) g = int'(s);
        if (!(exp_q.size() == 0 || qr)) g = -1;
        exp_dr = (g >= 0) ? NCH'(1 << g) : '0;
        chk("d_ready", d_ready, exp_dr);
        last_dready = d_ready;
        if (exp_q.size() != 0 && qr) begin
            chk("deliver_word", {q_src, q}, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (g >= 0) begin
            exp_q.push_back({SELW'(g), chan(d, g)});
            if (rr) m_ptr = (g + 1) % NCH;
        end
        @(posedge CLK); #1;
        chk("q_valid", q_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("q_word", {q_src, q}, exp_q[0]);
        chk("sel_err", sel_err, 1'b0);
    endtask

    task automatic step6(input logic ld, input logic [SELW-1:0] s, input logic [NCH6-1:0] dv,
                         input logic qr, input logic [NCH6-1:0] e_dr);
        load6 = ld; sel6 = s; d6_valid = dv; q6_ready = qr;
        @(negedge CLK);
        chk("d6_ready", d6_ready, e_dr);
        @(posedge CLK); #1;
    endtask

    typedef struct {
        logic            ld;
        logic [SELW-1:0] s;
        logic [NCH-1:0]  dv;
        logic            qr;
        logic [NCH-1:0]  e_dr;
        logic            e_qv;
        logic [WIDTH-1:0] e_q;
        logic [SELW-1:0] e_src;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 3'd3, 8'h08, 1'b1, 8'h08, 1'b1, 16'hBEEF, 3'd3};
        tbl[1] = '{1'b1, 3'd5, 8'h20, 1'b0, 8'h00, 1'b1, 16'hBEEF, 3'd3};
        tbl[2] = '{1'b1, 3'd5, 8'h20, 1'b0, 8'h00, 1'b1, 16'hBEEF, 3'd3};
        tbl[3] = '{1'b1, 3'd5, 8'h20, 1'b0, 8'h00, 1'b1, 16'hBEEF, 3'd3};
        tbl[4] = '{1'b1, 3'd5, 8'h20, 1'b1, 8'h20, 1'b1, 16'h0C05, 3'd5};
        tbl[5] = '{1'b1, 3'd2, 8'h00, 1'b1, 8'h00, 1'b0, 16'h0C05, 3'd5};
        tbl[6] = '{1'b0, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b0, 16'h0C05, 3'd5};
        tbl[7] = '{1'b1, 3'd7, 8'h80, 1'b0, 8'h80, 1'b1, 16'h0C07, 3'd7};
        tbl[8] = '{1'b1, 3'd0, 8'h01, 1'b1, 8'h01, 1'b1, 16'h0C00, 3'd0};
        tbl[9] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 16'h0C00, 3'd0};

        for (int i = 0; i < NCH; i++) d[i*WIDTH +: WIDTH] = 16'h0C00 + 16'(i);
        d[3*WIDTH +: WIDTH] = 16'hBEEF;
        d6 = '0; d6_valid = '0; load6 = 1'b0; sel6 = '0; mode6 = 1'b0; q6_ready = 1'b1;

        // Reset with an otherwise-capturable request pending.
        RSTN = 1'b0;
        load = 1'b1; sel = 3'd0; d_valid = 8'hFF; q_ready = 1'b1; mode = 1'b0;
        model_reset();
        #12;
        chk("rst_q", q, 16'h0);
        chk("rst_q_valid", q_valid, 1'b0);
        chk("rst_q_src", q_src, 3'd0);
        chk("rst_sel_err", sel_err, 1'b0);
        chk("rst_d_ready", d_ready, 8'h00);
        @(negedge CLK);
        RSTN = 1'b1;
        load = 1'b0; d_valid = '0;
        @(posedge CLK); #1;

        for (int i = 0; i < 10; i++) begin
            do_cycle(tbl[i].ld, tbl[i].s, tbl[i].dv, tbl[i].qr, 1'b0);
            chk($sformatf("tbl%0d_d_ready", i), last_dready, tbl[i].e_dr);
            chk($sformatf("tbl%0d_q_valid", i), q_valid, tbl[i].e_qv);
            chk($sformatf("tbl%0d_q", i), q, tbl[i].e_q);
            chk($sformatf("tbl%0d_q_src", i), q_src, tbl[i].e_src);
        end

        // Out-of-range select on the 6-channel instance.
        d6[5*WIDTH +: WIDTH] = 16'h5555;
        step6(1'b1, 3'd5, 6'h20, 1'b1, 6'h20);
        chk("d6_cap_q", q6, 16'h5555);
        chk("d6_cap_src", q6_src, 3'd5);
        chk("d6_cap_valid", q6_valid, 1'b1);
        chk("d6_inrange_err", sel6_err, 1'b0);
        step6(1'b1, 3'd6, 6'h3F, 1'b1, 6'h00);
        chk("d6_sel6_err", sel6_err, 1'b1);
        chk("d6_sel6_valid", q6_valid, 1'b0);
        chk("d6_sel6_q_kept", q6, 16'h5555);
        RSTN = 1'b0; #2;
        chk("d6_err_cleared", sel6_err, 1'b0);
        RSTN = 1'b1;
        @(posedge CLK); #1;
        step6(1'b1, 3'd7, 6'h3F, 1'b1, 6'h00);
        chk("d6_sel7_err", sel6_err, 1'b1);
        chk("d6_sel7_valid", q6_valid, 1'b0);
        for (int i = 0; i < 10; i++) step6(1'b0, 3'd0, 6'h00, 1'b1, 6'h00);
        chk("d6_err_sticky", sel6_err, 1'b1);

        // Asynchronous reset while a word is held under backpressure.
        d[1*WIDTH +: WIDTH] = 16'h1234;
        do_cycle(1'b1, 3'd1, 8'h02, 1'b0, 1'b0);
        do_cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        chk("held_q", q, 16'h1234);
        chk("held_valid", q_valid, 1'b1);
        load = 1'b1; sel = 3'd1; d_valid = 8'h02; q_ready = 1'b1;
        #3;
        RSTN = 1'b0;
        #1;
        chk("async_rst_q", q, 16'h0);
        chk("async_rst_valid", q_valid, 1'b0);
        chk("async_rst_src", q_src, 3'd0);
        chk("async_rst_sel_err", sel6_err, 1'b0);
        chk("async_rst_d_ready", d_ready, 8'h00);
        #2;
        RSTN = 1'b1;
        model_reset();
        load = 1'b0; d_valid = '0;
        @(posedge CLK); #1;

`ifdef MUXREG_PIPE_RR_EN
        // Round-robin wrap between channels 0 and 7 starting from ptr=0.
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 3'd3, 8'h81, 1'b1, 1'b1);
            chk($sformatf("rr%0d_d_ready", i), last_dready, (i % 2 == 0) ? 8'h01 : 8'h80);
            chk($sformatf("rr%0d_q_src", i), q_src, (i % 2 == 0) ? 3'd0 : 3'd7);
        end
`else
        // mode is ignored without the arbiter: behaves as explicit select.
        do_cycle(1'b1, 3'd2, 8'h04, 1'b1, 1'b1);
        chk("nrr_d_ready", last_dready, 8'h04);
        chk("nrr_q", q, 16'h0C02);
        chk("nrr_q_src", q_src, 3'd2);
        do_cycle(1'b0, 3'd0, 8'hFF, 1'b1, 1'b1);
        chk("nrr_noload_d_ready", last_dready, 8'h00);
        chk("nrr_noload_valid", q_valid, 1'b0);
`endif

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) d[i*WIDTH +: WIDTH] = 16'($urandom);
            do_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                     1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
